// File: rtl/dcache_wb_if.sv
// Processor and system-bus signal bundle for the write-back data cache.
// slave is the cache's view; master is the processor/bus side.
interface dcache_wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PStrobe;
    logic              PRw;
    logic [ADDR_W-1:0] PAddress;
    logic [DATA_W-1:0] PData_out;
    logic [DATA_W-1:0] PData_in;
    logic              CReady;
    logic              SysStrobe;
    logic              SysRW;
    logic [ADDR_W-1:0] SysAddress;
    logic [DATA_W-1:0] SysData_in;
    logic [DATA_W-1:0] SysData_out;
    logic              SysAck;
    logic              SysReady;

    modport slave (
        input  PStrobe, PRw, PAddress, PData_out,
        input  SysData_out, SysAck, SysReady,
        output PData_in, CReady,
        output SysStrobe, SysRW, SysAddress, SysData_in
    );

    modport master (
        output PStrobe, PRw, PAddress, PData_out,
        output SysData_out, SysAck, SysReady,
        input  PData_in, CReady,
        input  SysStrobe, SysRW, SysAddress, SysData_in
    );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with burst
// victim writeback and line refill over the system bus.
module dcache_wb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BOFS_W = 2,
    parameter int IDX_W  = 6,
    parameter int OFS_W  = 4,
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W - BOFS_W
) (
    input  logic        clock,
    input  logic        reset,
    dcache_wb_if.slave  bus
);
    localparam int NL = 1 << IDX_W;
    localparam int NW = 1 << OFS_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WBACK  = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;

    logic [1:0]       state;
    logic [OFS_W-1:0] cnt;
    logic [NL-1:0]    valid;
    logic [NL-1:0]    dirty;
    logic [TAG_W-1:0] tags [NL];
    logic [DATA_W-1:0] data [NL*NW];

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFS_W-1:0] wofs;
    logic             idle;
    logic             hit;
    logic             wr_hit;
    logic             fill_ack;

    assign tag  = bus.PAddress[ADDR_W-1 -: TAG_W];
    assign idx  = bus.PAddress[BOFS_W+OFS_W +: IDX_W];
    assign wofs = bus.PAddress[BOFS_W +: OFS_W];

    generate
        if (BOFS_W > 0) begin : g_bofs
            logic unused_bofs;
            assign unused_bofs = ^bus.PAddress[BOFS_W-1:0];
        end
    endgenerate

    assign idle     = (state == IDLE);
    assign hit      = bus.PStrobe & valid[idx] & (tags[idx] == tag);
    assign wr_hit   = idle & hit & ~bus.PRw;
    assign fill_ack = (state == REFILL) & bus.SysAck;

    always_comb begin
        bus.CReady     = idle & hit;
        bus.PData_in   = (idle & hit) ? data[{idx, wofs}] : '0;
        bus.SysStrobe  = (state == WBACK) | (state == REFILL);
        bus.SysRW      = (state != WBACK);
        bus.SysAddress = '0;
        bus.SysData_in = '0;
        case (state)
            WBACK: begin
                bus.SysAddress = {tags[idx], idx, cnt, {BOFS_W{1'b0}}};
                bus.SysData_in = data[{idx, cnt}];
            end
            REFILL: begin
                bus.SysAddress = {tag, idx, cnt, {BOFS_W{1'b0}}};
            end
            default: ;
        endcase
    end

    // Control state; tag and data arrays below are deliberately not reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.PStrobe & ~hit)
                        state <= (valid[idx] & dirty[idx]) ? WBACK : REFILL;
                    else if (wr_hit)
                        dirty[idx] <= 1'b1;
                end
                WBACK: begin
                    if (bus.SysAck)
                        cnt <= cnt + 1'b1;
                    if (bus.SysReady) begin
                        cnt        <= '0;
                        dirty[idx] <= 1'b0;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.SysAck)
                        cnt <= cnt + 1'b1;
                    if (bus.SysReady) begin
                        cnt        <= '0;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_hit)
            data[{idx, wofs}] <= bus.PData_out;
        if (fill_ack)
            data[{idx, cnt}] <= bus.SysData_out;
        if ((state == REFILL) & bus.SysReady)
            tags[idx] <= tag;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Randomised bench for dcache_wb: two geometries against a flat-memory
// reference with a per-line cache-state model and a bus-slave memory.
module tb_dcache_wb;
    logic        clock;
    logic        reset;
    logic        sel;
    logic        PStrobe;
    logic        PRw;
    logic [31:0] PAddress;
    logic [31:0] PData_out;
    logic [31:0] SysData_out;
    logic        SysAck;
    logic        SysReady;

    dcache_wb_if #(.ADDR_W(32), .DATA_W(32)) i0 ();
    dcache_wb_if #(.ADDR_W(32), .DATA_W(32)) i1 ();

    dcache_wb u0 (.clock(clock), .reset(reset), .bus(i0));
    dcache_wb #(.IDX_W(2), .OFS_W(1)) u1 (.clock(clock), .reset(reset), .bus(i1));

    assign i0.PStrobe     = PStrobe & ~sel;
    assign i0.PRw         = PRw;
    assign i0.PAddress    = PAddress;
    assign i0.PData_out   = PData_out;
    assign i0.SysData_out = SysData_out;
    assign i0.SysAck      = SysAck & ~sel;
    assign i0.SysReady    = SysReady & ~sel;
    assign i1.PStrobe     = PStrobe & sel;
    assign i1.PRw         = PRw;
    assign i1.PAddress    = PAddress;
    assign i1.PData_out   = PData_out;
    assign i1.SysData_out = SysData_out;
    assign i1.SysAck      = SysAck & sel;
    assign i1.SysReady    = SysReady & sel;

    wire        c_ready  = sel ? i1.CReady     : i0.CReady;
    wire [31:0] p_rdata  = sel ? i1.PData_in   : i0.PData_in;
    wire        s_strobe = sel ? i1.SysStrobe  : i0.SysStrobe;
    wire        s_rw     = sel ? i1.SysRW      : i0.SysRW;
    wire [31:0] s_addr   = sel ? i1.SysAddress : i0.SysAddress;
    wire [31:0] s_wdata  = sel ? i1.SysData_in : i0.SysData_in;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int same_mode = 0;

    logic [31:0] gmem [longint];
    logic [31:0] bmem [longint];
    logic [31:0] mtag   [2][64];
    bit          mvalid [2][64];
    bit          mdirty [2][64];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint key(input int s, input logic [31:0] a);
        return (longint'(s) << 32) | longint'(a & 32'hFFFF_FFFC);
    endfunction

    function automatic logic [31:0] init_val(input longint k);
        return 32'(k * 64'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] gold_rd(input int s, input logic [31:0] a);
        longint k = key(s, a);
        return gmem.exists(k) ? gmem[k] : init_val(k);
    endfunction

    function automatic logic [31:0] bus_rd(input int s, input logic [31:0] a);
        longint k = key(s, a);
        return bmem.exists(k) ? bmem[k] : init_val(k);
    endfunction

    // Reset loses every line: the processor view falls back to bus memory.
    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) begin
                mvalid[s][i] = 1'b0;
                mdirty[s][i] = 1'b0;
            end
        gmem = bmem;
    endtask

    task automatic burst(input int s, input bit rd, input logic [31:0] base,
                         input int nw, input int abort, output bit ab);
        bit same;
        logic [31:0] ea;
        ab = 1'b0;
        same = 1'b0;
        for (int k = 0; k < nw; k++) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clock);
                SysAck = 1'b0;
                SysReady = 1'b0;
                #1;
                check("gap_strobe", 32'(s_strobe), 32'd1);
            end
            if (k == abort) begin
                @(negedge clock);
                reset = 1'b0;
                SysAck = 1'b0;
                SysReady = 1'b0;
                PStrobe = 1'b0;
                #1;
                check("rst_strobe", 32'(s_strobe), 32'd0);
                check("rst_creq", 32'(c_ready), 32'd0);
                check("rst_rw", 32'(s_rw), 32'd1);
                check("rst_addr", s_addr, 32'd0);
                check("rst_rdata", p_rdata, 32'd0);
                @(negedge clock);
                reset = 1'b1;
                model_reset();
                ab = 1'b1;
                return;
            end
            @(negedge clock);
            ea = base + 32'(k * 4);
            same = (k == nw - 1) &&
                   (same_mode == 1 || (same_mode == 0 && $urandom_range(0, 1) == 1));
            SysAck = 1'b1;
            SysReady = same;
            SysData_out = rd ? bus_rd(s, ea) : $urandom;
            #1;
            check("bus_strobe", 32'(s_strobe), 32'd1);
            check("bus_rw", 32'(s_rw), 32'(rd));
            check("bus_addr", s_addr, ea);
            check("bus_creq", 32'(c_ready), 32'd0);
            if (!rd) begin
                check("wb_data", s_wdata, gold_rd(s, ea));
                bmem[key(s, ea)] = gold_rd(s, ea);
            end
        end
        if (!same) begin
            @(negedge clock);
            SysAck = 1'b0;
            SysReady = 1'b1;
            #1;
            check("rdy_strobe", 32'(s_strobe), 32'd1);
        end
    endtask

    task automatic access(input int s, input bit rw, input logic [31:0] a,
                          input logic [31:0] wd, input int abort);
        int ofs, ixw, nw, idx;
        logic [31:0] tg, lb, vb;
        bit h, ab;
        ofs = s ? 1 : 4;
        ixw = s ? 2 : 6;
        nw  = 1 << ofs;
        idx = int'((a >> (2 + ofs)) & 32'((1 << ixw) - 1));
        tg  = a >> (2 + ofs + ixw);
        lb  = a & ~(32'(nw * 4) - 32'd1);
        h   = mvalid[s][idx] && mtag[s][idx] == tg;
        @(negedge clock);
        sel = s[0];
        PStrobe = 1'b1;
        PRw = rw;
        PAddress = a;
        PData_out = wd;
        SysAck = 1'b0;
        SysReady = 1'b0;
        #1;
        check("creq_first", 32'(c_ready), 32'(h));
        if (!h) begin
            if (mvalid[s][idx] && mdirty[s][idx]) begin
                vb = (mtag[s][idx] << (2 + ofs + ixw)) | 32'(idx << (2 + ofs));
                burst(s, 1'b0, vb, nw, -1, ab);
                mdirty[s][idx] = 1'b0;
            end
            burst(s, 1'b1, lb, nw, abort, ab);
            if (ab)
                return;
            mvalid[s][idx] = 1'b1;
            mtag[s][idx]   = tg;
            mdirty[s][idx] = 1'b0;
            @(negedge clock);
            SysAck = 1'b0;
            SysReady = 1'b0;
            #1;
            check("creq_after_fill", 32'(c_ready), 32'd1);
        end
        check("hit_nostrobe", 32'(s_strobe), 32'd0);
        if (rw) begin
            check("rdata", p_rdata, gold_rd(s, a));
        end else begin
            gmem[key(s, a)] = wd;
            mdirty[s][idx] = 1'b1;
        end
    endtask

    // Idle cycle with stray bus strobes that must be ignored.
    task automatic idle_cycle();
        @(negedge clock);
        PStrobe = 1'b0;
        sel = 1'($urandom_range(0, 1));
        SysAck = 1'($urandom_range(0, 1));
        SysReady = 1'($urandom_range(0, 1));
        #1;
        check("idle_creq", 32'(c_ready), 32'd0);
        check("idle_strobe", 32'(s_strobe), 32'd0);
        check("idle_addr", s_addr, 32'd0);
        check("idle_wdata", s_wdata, 32'd0);
    endtask

    initial begin
        int s, nw, tg, idx, wo, ab;
        logic [31:0] a;
        reset = 1'b0;
        sel = 1'b0;
        PStrobe = 1'b0;
        PRw = 1'b1;
        PAddress = '0;
        PData_out = '0;
        SysData_out = '0;
        SysAck = 1'b0;
        SysReady = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        check("por_creq", 32'(c_ready), 32'd0);
        check("por_strobe", 32'(s_strobe), 32'd0);
        check("por_rw", 32'(s_rw), 32'd1);
        check("por_addr", s_addr, 32'd0);
        check("por_wdata", s_wdata, 32'd0);
        check("por_rdata", p_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        access(0, 1'b1, 32'h0000_1004, 32'h0, -1);
        access(0, 1'b1, 32'h0000_1038, 32'h0, -1);
        access(0, 1'b0, 32'h0000_1008, 32'hDEAD_BEEF, -1);
        access(0, 1'b1, 32'h0000_1008, 32'h0, -1);
        access(0, 1'b1, 32'h0000_2008, 32'h0, -1);
        access(0, 1'b1, 32'h0000_1008, 32'h0, -1);
        idle_cycle();
        access(0, 1'b1, 32'h0000_3010, 32'h0, 5);
        access(0, 1'b1, 32'h0000_3010, 32'h0, -1);
        access(0, 1'b1, 32'h0000_1008, 32'h0, -1);

        same_mode = 1;
        access(1, 1'b1, 32'h0000_0018, 32'h0, -1);
        access(1, 1'b0, 32'h0000_001C, 32'h1234_5678, -1);
        access(1, 1'b1, 32'h0000_0020, 32'h0, -1);
        access(1, 1'b1, 32'h0000_0058, 32'h0, -1);
        access(1, 1'b1, 32'h0000_001C, 32'h0, -1);
        same_mode = 0;

        for (int n = 0; n < 300; n++) begin
            s   = $urandom_range(0, 1);
            tg  = $urandom_range(0, 3);
            if (s == 0) begin
                idx = ($urandom_range(0, 4) == 4) ? 63 : $urandom_range(0, 3);
                wo  = $urandom_range(0, 15);
                a   = 32'((tg << 12) | (idx << 6) | (wo << 2));
                nw  = 16;
            end else begin
                idx = $urandom_range(0, 3);
                wo  = $urandom_range(0, 1);
                a   = 32'((tg << 5) | (idx << 3) | (wo << 2));
                nw  = 2;
            end
            ab = ($urandom_range(0, 39) == 0) ? $urandom_range(0, nw - 1) : -1;
            access(s, 1'($urandom_range(0, 1)), a, $urandom, ab);
            if ($urandom_range(0, 3) == 0)
                idle_cycle();
        end

        idle_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
